// File: rtl/wb_resp_pkg.sv
// Shared types and helpers for the Wishbone classic-cycle slave responder.
package wb_resp_pkg;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_SELW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Word-index width for a register file of the given depth (at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Expand byte-lane enables into a 32-bit data mask.
  function automatic logic [WB_DW-1:0] lane_mask(input logic [WB_SELW-1:0] sel);
    logic [WB_DW-1:0] m;
    m = '0;
    for (int unsigned l = 0; l < WB_SELW; l++) begin
      m[8*l +: 8] = {8{sel[l]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_resp_regfile.sv
// DEPTH x 32 register file: async clear, per-byte-lane write, combinational read.
module wb_resp_regfile
  import wb_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IW    = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [IW-1:0]      widx_i,
  input  logic [WB_SELW-1:0] be_i,
  input  logic [WB_DW-1:0]   wdata_i,
  input  logic [IW-1:0]      ridx_i,
  output logic [WB_DW-1:0]   rdata_o
);

  logic [WB_DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int unsigned l = 0; l < WB_SELW; l++) begin
        if (be_i[l]) begin
          mem_q[widx_i][8*l +: 8] <= wdata_i[8*l +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/wb_slave_responder.sv
// Wishbone classic-cycle slave with wait states, range error and transfer counter.
// Optional build macro WB_RESP_RETRY_EN: every RETRY_PERIODth in-range request is retried.
module wb_slave_responder
  import wb_resp_pkg::*;
#(
  parameter int unsigned   AW           = 32,
  parameter int unsigned   DEPTH        = 16,
  parameter logic [AW-1:0] BASE_ADDR    = AW'(32'h0000_1000),
  parameter int unsigned   RETRY_PERIOD = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [AW-1:0]      wb_adr_i,
  input  logic [WB_DW-1:0]   wb_dat_i,
  output logic [WB_DW-1:0]   wb_dat_o,
  input  logic [WB_SELW-1:0] wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_stb_i,
  input  logic               wb_cyc_i,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  input  logic [3:0]         wait_states_i,
  output logic [15:0]        access_count_o
);

  localparam int unsigned   IW   = idx_width(DEPTH);
  localparam logic [AW-1:0] SPAN = AW'(4 * DEPTH);

  if (RETRY_PERIOD == 0 || DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0)
  begin : g_param_check
    $error("wb_slave_responder: bad DEPTH or RETRY_PERIOD");
  end

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [WB_DW-1:0]   wdat_q, wdat_d;
  logic [WB_SELW-1:0] sel_q, sel_d;
  logic               we_q, we_d;
  logic [3:0]         wait_q, wait_d;
  logic               inr_q, inr_d;
  logic               pend_q, pend_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               rty_q, rty_d;
  logic [WB_DW-1:0]   rdat_q, rdat_d;
  logic [15:0]        cnt_q, cnt_d;

  logic [AW-1:0]      off_c;
  logic               in_range_c;
  logic               acc_c;
  logic               commit_c;
  logic               retry_hit_c;
  logic               wr_en_c;
  logic [WB_DW-1:0]   rd_word_c;

  assign off_c      = wb_adr_i - BASE_ADDR;
  assign in_range_c = (wb_adr_i >= BASE_ADDR) && (off_c < SPAN);
  assign acc_c      = (state_q == IDLE) && wb_cyc_i && wb_stb_i;

`ifdef WB_RESP_RETRY_EN
  localparam int unsigned RCW = (RETRY_PERIOD < 2) ? 1 : $clog2(RETRY_PERIOD);
  logic [RCW-1:0] rcnt_q, rcnt_d;

  // Counts in-range accepted requests; the slot before wrap is the retried one.
  assign retry_hit_c = (rcnt_q == RCW'(RETRY_PERIOD - 1));
  assign rcnt_d      = (acc_c && in_range_c) ? (retry_hit_c ? '0 : rcnt_q + RCW'(1)) : rcnt_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) rcnt_q <= '0;
    else           rcnt_q <= rcnt_d;
  end
`else
  assign retry_hit_c = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    wait_d   = wait_q;
    inr_d    = inr_q;
    pend_d   = pend_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rty_d    = 1'b0;
    rdat_d   = '0;
    cnt_d    = cnt_q;
    commit_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc_c) begin
          idx_d  = off_c[IW+1:2];
          wdat_d = wb_dat_i;
          sel_d  = wb_sel_i;
          we_d   = wb_we_i;
          wait_d = wait_states_i;
          inr_d  = in_range_c;
          pend_d = in_range_c && retry_hit_c;
          if (wait_states_i == 4'd0) begin
            state_d  = RESP;
            commit_c = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Initiator abandoning the cycle wins over the final wait tick.
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          wait_d = wait_q - 4'd1;
          if (wait_q == 4'd1) begin
            state_d  = RESP;
            commit_c = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        if (!inr_q) begin
          err_d = 1'b1;
        end else if (pend_q) begin
          rty_d = 1'b1;
        end else begin
          ack_d = 1'b1;
          if (!we_q) rdat_d = rd_word_c & lane_mask(sel_q);
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write lands on the edge entering RESP; _d values cover the zero-wait case.
  assign wr_en_c = commit_c && inr_d && we_d && !pend_d;

  wb_resp_regfile #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_regfile (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_i),
    .we_i    (wr_en_c),
    .widx_i  (idx_d),
    .be_i    (sel_d),
    .wdata_i (wdat_d),
    .ridx_i  (idx_q),
    .rdata_o (rd_word_c)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      wait_q  <= '0;
      inr_q   <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      rdat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wait_q  <= wait_d;
      inr_q   <= inr_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      rdat_q  <= rdat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_ack_o       = ack_q;
  assign wb_err_o       = err_q;
  assign wb_rty_o       = rty_q;
  assign wb_dat_o       = rdat_q;
  assign access_count_o = cnt_q;

endmodule

// File: doc/wb_slave_responder.md
Name: wb_slave_responder

Overview:
- Wishbone classic-cycle slave model: the responding end for the bench's Wishbone initiator driver.
- Holds a small byte-lane-writable register file and inserts programmable wait states.
- Flags out-of-range accesses with an error response; counts completed transfers.
- Used standalone to qualify the Wishbone driver and as a stand-in peripheral next to the quad UART.

Parameters:
- AW, 32, address width.
- DEPTH, 16, number of 32-bit words (power of two, 2..256).
- BASE_ADDR, 32'h0000_1000, byte address of word 0.
- RETRY_PERIOD, 4, every Nth accepted request is retried. Only used with WB_RESP_RETRY_EN.

Ports:
- wb_clk_i  in  1  bus clock.
- wb_rst_i  in  1  reset; asynchronous, active-low.
- wb_adr_i  in  AW  byte address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_sel_i  in  4  byte lane enables; bit n selects [8n+7:8n].
- wb_we_i  in  1  1 = write.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle valid.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  retry termination.
- wait_states_i  in  4  extra wait cycles per access, sampled at request acceptance.
- access_count_o  out  16  number of acked transfers.

Behaviour:
- Reset (wb_rst_i low, async):
  - State IDLE.
  - wb_ack_o, wb_err_o and wb_rty_o are 0; wb_dat_o is 0; access_count_o is 0.
  - All register-file words are 0; the retry counter is 0.
  - Reset asserted mid-transfer aborts the transfer with no response and no write.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on the edge where wb_cyc_i & wb_stb_i is sampled, latch adr, dat, sel, we and W = wait_states_i. Go to WAIT if W > 0, else to RESP.
  - WAIT: decrement W each cycle. Go to RESP at the edge where W reaches 1→0.
  - If wb_cyc_i is low in WAIT, return to IDLE with no response and no write.
  - RESP: exactly one termination output is high for exactly one cycle, then the FSM returns to IDLE. The bus is not sampled on that edge.
- Latency: request sampled at edge k → response visible after edge k+1+W. Minimum back-to-back period is 2+W cycles.
- Address decode:
  - In range ⇔ BASE_ADDR ≤ adr < BASE_ADDR + 4*DEPTH.
  - Word index = (adr − BASE_ADDR) >> 2; adr[1:0] is ignored.
  - Out of range → wb_err_o instead of ack. No write, wb_dat_o = 0.
- Write:
  - Committed at the edge entering RESP, using the latched address, data and sel.
  - Only lanes with sel = 1 are updated. sel = 0 still acks with no change.
- Read:
  - wb_dat_o = word contents during the ack cycle. Unselected lanes return 0.
  - wb_dat_o = 0 in every non-ack cycle.
- A same-cycle write and read cannot occur (single outstanding transfer).
- access_count_o:
  - Increments on each ack cycle (read or write), not on err or rty.
  - Saturates at 16'hFFFF.
- wb_cyc_i dropping while in RESP does not cancel the already-issued termination.

Optional Feature:
- Macro: WB_RESP_RETRY_EN.
- Defined:
  - The retry counter counts in-range accepted requests modulo RETRY_PERIOD.
  - The request that wraps the counter to 0 (the RETRY_PERIODth, 2*RETRY_PERIODth, ...) terminates with wb_rty_o instead of ack.
  - A retried request performs no write and does not increment access_count_o.
  - err takes precedence: out-of-range requests never advance the counter.
- Undefined: wb_rty_o is tied 0, and no retry counter is built.

Decomposition:
- Package wb_resp_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - WB_DW = 32 and WB_SELW = 4;
  - an index-width helper function (clog2 of DEPTH).
- Sub-module wb_resp_regfile: DEPTH×32 storage with an async-clear, a per-lane write enable and a combinational read port.
- The FSM, decode, counters and output registers stay in wb_slave_responder.

Test Plan:
- Reset, then write 32'hDEADBEEF to 32'h1000 with sel=4'hF and wait_states_i=0; read 32'h1000 → ack one cycle after each request, read data 32'hDEADBEEF, access_count_o=2.
- Write 32'h11223344 to 32'h1004 with sel=4'hF, then write 32'hAABBCCDD with sel=4'b0101; read 32'h1004 → 32'h11BB33DD.
- wait_states_i=5, read 32'h1000 → ack asserted exactly 6 cycles after the request edge and high for 1 cycle.
- Access 32'h1040 with DEPTH=16, then 32'h0FFC → wb_err_o pulses for each, wb_dat_o=0, access_count_o unchanged.
- wait_states_i=7: issue a write, drop wb_cyc_i after 3 cycles, then read the same address → no termination on the aborted access, old data returned.
- WB_RESP_RETRY_EN with RETRY_PERIOD=4: issue 8 writes to 32'h1008 with data 1..8 → the 4th and 8th writes get wb_rty_o, read back returns 7, access_count_o=7 (6 writes plus the read).
